// File: rtl/mix_columns_seq_pkg.sv
// Shared types for the sequential masked MixColumns stage.
// A byte is carried as D+1 shares; its value is share[D] ^ sum_i L[i]*share[i].
package mix_columns_seq_pkg;

    localparam int D = 1;

    typedef logic [7:0]                  red_poly_t;
    typedef red_poly_t [0:D]             share_vec_t;
    typedef share_vec_t [0:3]            col_vec_t;
    typedef share_vec_t [0:3][0:3]       state_vec_t;
    typedef red_poly_t [0:D-1]           mm_matrix_t;
    typedef red_poly_t [0:D-1][0:3]      mc_m_matrix_t;
    typedef red_poly_t [0:3][0:3]        mn_matrix_t;
    typedef red_poly_t [0:15]            col_rand_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mcs_state_t;

    // GF(2^8) multiply, AES polynomial x^8 + x^4 + x^3 + x + 1
    function automatic red_poly_t gf_mul(input red_poly_t a, input red_poly_t b);
        red_poly_t acc;
        red_poly_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_columns_seq_col.sv
// One masked column: share-wise matrix multiply followed by a mask refresh.
// The refresh adds B_ext_MC*r to the first D shares and folds the
// L-weighted sum of those masks into the last share, so the decoded value
// is unchanged while every share is re-randomised.
module mix_column_single
    import mix_columns_seq_pkg::*;
#(
    parameter int d = D
) (
    input  col_vec_t     col_in,
    input  col_rand_t    rand_in,
    input  mn_matrix_t   M,
    input  mm_matrix_t   L,
    input  mc_m_matrix_t B_ext_MC,
    output col_vec_t     col_out
);

    if (d != D) begin : g_bad_order
        $error("mix_column_single: masking order d must equal package D");
    end

    col_vec_t                mixed;
    red_poly_t [0:3][0:D-1]  mask;

    // MixColumns is linear, so each share goes through the matrix on its own
    always_comb begin
        mixed = '0;
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s <= D; s++) begin
                for (int c = 0; c < 4; c++) begin
                    mixed[r][s] = mixed[r][s] ^ gf_mul(M[r][c], col_in[c][s]);
                end
            end
        end
    end

    // fresh per-byte masks: four random entries per byte, one set per share
    always_comb begin
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < D; i++) begin
                for (int j = 0; j < 4; j++) begin
                    mask[k][i] = mask[k][i] ^ gf_mul(B_ext_MC[i][j], rand_in[4*k + j]);
                end
            end
        end
    end

    // apply masks and compensate in the last share
    always_comb begin
        col_out = mixed;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < D; i++) begin
                col_out[k][i] = col_out[k][i] ^ mask[k][i];
                col_out[k][D] = col_out[k][D] ^ gf_mul(L[i], mask[k][i]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential masked MixColumns: accepts one state, runs P columns per beat
// through shared column units with fresh randomness per beat, then holds the
// result until the downstream stage takes it.
//
//   state | meaning
//   IDLE  | waiting for a state, in_ready high
//   BUSY  | consuming one column group per rand_valid beat
//   DONE  | out holds the finished state, out_valid high
module mix_columns_seq
    import mix_columns_seq_pkg::*;
#(
    parameter int d = D,
    parameter int P = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  state_vec_t         in,
    input  logic               in_inv,
    input  logic               rand_valid,
    output logic               rand_ready,
    input  col_rand_t [0:P-1]  random_vect,
    input  mm_matrix_t         L,
    input  mc_m_matrix_t       B_ext_MC,
    input  mn_matrix_t         MC,
    input  mn_matrix_t         MC_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output state_vec_t         out
);

    localparam int NBEATS = 4 / P;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    if (!(P == 1 || P == 2 || P == 4)) begin : g_bad_p
        $error("mix_columns_seq: P must be 1, 2 or 4");
    end

    logic [1:0]       state_q;
    logic [BW-1:0]    beat_q;
    logic             mode_q;
    col_vec_t [0:3]   work_q;

    logic             accept;
    logic             last_beat;
    mn_matrix_t       mc_sel;
    col_vec_t         grp_in  [P];
    col_vec_t         grp_out [P];

    assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign rand_ready = (state_q == S_BUSY);
    assign out_valid  = (state_q == S_DONE);
    assign accept     = in_valid && in_ready;
    assign last_beat  = (beat_q == BW'(NBEATS - 1));
    assign mc_sel     = mode_q ? MC_inv : MC;

    // select the column group addressed by the current beat
    always_comb begin
        for (int g = 0; g < P; g++) grp_in[g] = '0;
        for (int c = 0; c < 4; c++) begin
            if (c / P == int'(beat_q)) grp_in[c % P] = work_q[c];
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_col
        mix_column_single #(.d(d)) u_col (
            .col_in   (grp_in[g]),
            .rand_in  (random_vect[g]),
            .M        (mc_sel),
            .L        (L),
            .B_ext_MC (B_ext_MC),
            .col_out  (grp_out[g])
        );
    end

    // control FSM and column-major work register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
        end else begin
            if (accept) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        work_q[c][r] <= in[r][c];
                    end
                end
                mode_q  <= in_inv;
                beat_q  <= '0;
                state_q <= S_BUSY;
            end else if (state_q == S_BUSY) begin
                if (rand_valid) begin
                    for (int c = 0; c < 4; c++) begin
                        if (c / P == int'(beat_q)) work_q[c] <= grp_out[c % P];
                    end
                    if (last_beat) begin
                        beat_q  <= '0;
                        state_q <= S_DONE;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
            end else if (state_q == S_DONE) begin
                if (out_ready) state_q <= S_IDLE;
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    // present the work register back in row/column order
    always_comb begin
        out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                out[r][c] = work_q[c][r];
            end
        end
    end

endmodule
